// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: registered MIPS ID stage producing the ID/EX control bundle
// with stall/flush handling and a load-use interlock of configurable depth.
module id_ctrl_stage #(
    parameter int IFID_W        = 64,
    parameter int INSTR_LSB     = 0,
    parameter int LOAD_BUBBLES  = 1,
    parameter bit ENABLE_HAZARD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IFID_W-1:0] ifid_reg,
    input  logic              ifid_valid,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              id_ready,
    output logic              hazard_stall,
    output logic              idex_valid,
    output logic [IFID_W-1:0] idex_ifid,
    output logic              ExtOp,
    output logic              ImmCh,
    output logic              ShamtCh,
    output logic              ShiftCtr,
    output logic              MemRead,
    output logic              MemWrite
);
    localparam logic [1:0] LB = LOAD_BUBBLES[1:0];
    logic [5:0] op, funct;
    logic [4:0] rs, rt, pend_rt;
    logic [1:0] pend_cnt;
    logic ext_op, imm_ch, shamt_ch, shift_ctr, mem_read, mem_write;
    logic uses_rs, uses_rt, hazard, issue;
    assign op    = ifid_reg[INSTR_LSB+26 +: 6];
    assign funct = ifid_reg[INSTR_LSB +: 6];
    assign rs    = ifid_reg[INSTR_LSB+21 +: 5];
    assign rt    = ifid_reg[INSTR_LSB+16 +: 5];
    assign ext_op = op inside {6'b001000, 6'b001001, 6'b000100, 6'b000101, 6'b100011, 6'b101011, 6'b001010,
                               6'b001011, 6'b000001, 6'b000111, 6'b000110, 6'b100000, 6'b100100, 6'b101000};
    assign imm_ch    = (op[5:3] == 3'b001) || (op inside {6'b100011, 6'b101011, 6'b100000, 6'b100100, 6'b101000});
    assign shamt_ch  = (op == 6'd0) && (funct inside {6'b000000, 6'b000010, 6'b000011});
    assign shift_ctr = (op == 6'd0) && (funct inside {6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111});
    assign mem_read  = op inside {6'b100011, 6'b100000, 6'b100100};
    assign mem_write = op inside {6'b101011, 6'b101000};
    assign uses_rs = !(shamt_ch || (op inside {6'b000010, 6'b000011, 6'b001111}));
    assign uses_rt = (op == 6'd0) || (op inside {6'b000100, 6'b000101, 6'b101011, 6'b101000});
    assign hazard = ENABLE_HAZARD && ifid_valid && !flush && (pend_cnt != 2'd0) &&
                    ((uses_rs && rs == pend_rt) || (uses_rt && rt == pend_rt));
    assign hazard_stall = hazard && !ex_stall;
    assign id_ready     = !ex_stall && !hazard;
    assign issue        = ifid_valid && !flush && !hazard;
    // Every advancing edge consumes one pending bubble unless a new load restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_valid <= 1'b0;
            idex_ifid  <= '0;
            {ExtOp, ImmCh, ShamtCh, ShiftCtr, MemRead, MemWrite} <= '0;
            pend_rt    <= '0;
            pend_cnt   <= '0;
        end else if (!ex_stall) begin
            idex_valid <= issue;
            idex_ifid  <= ifid_reg;
            {ExtOp, ImmCh, ShamtCh, ShiftCtr, MemRead, MemWrite} <=
                issue ? {ext_op, imm_ch, shamt_ch, shift_ctr, mem_read, mem_write} : 6'd0;
            if (issue && mem_read && rt != 5'd0) begin
                pend_rt  <= rt;
                pend_cnt <= LB;
            end else if (pend_cnt != 2'd0) begin
                pend_cnt <= pend_cnt - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb_id_ctrl_stage: checks two instances (1 and 2 load bubbles) against a
// behavioural pipeline model under directed and randomized instruction streams.
module tb_id_ctrl_stage;
    localparam int W = 64;
    typedef struct {logic [31:0] ins; bit v, st, fl, r;} stim_t;
    logic clk = 1'b0, rst = 1'b1, ifid_valid = 1'b0, ex_stall = 1'b0, flush = 1'b0;
    logic [W-1:0] ifid_reg = '0;
    logic [1:0] id_ready, hazard_stall, idex_valid;
    logic [W-1:0] f0, f1;
    logic [5:0] c0, c1;
    int total = 0, passed = 0;
    int bub[2] = '{1, 2};
    int m_cnt[2] = '{0, 0};
    logic [4:0] m_rt[2];
    bit m_v[2];
    logic [5:0] m_c[2];
    logic [W-1:0] m_ifid[2];

    always #5 clk = ~clk;

    id_ctrl_stage #(.IFID_W(W), .INSTR_LSB(0), .LOAD_BUBBLES(1), .ENABLE_HAZARD(1'b1)) dut0 (
        .clk(clk), .rst(rst), .ifid_reg(ifid_reg), .ifid_valid(ifid_valid), .ex_stall(ex_stall),
        .flush(flush), .id_ready(id_ready[0]), .hazard_stall(hazard_stall[0]), .idex_valid(idex_valid[0]),
        .idex_ifid(f0), .ExtOp(c0[5]), .ImmCh(c0[4]), .ShamtCh(c0[3]), .ShiftCtr(c0[2]),
        .MemRead(c0[1]), .MemWrite(c0[0]));
    id_ctrl_stage #(.IFID_W(W), .INSTR_LSB(0), .LOAD_BUBBLES(2), .ENABLE_HAZARD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .ifid_reg(ifid_reg), .ifid_valid(ifid_valid), .ex_stall(ex_stall),
        .flush(flush), .id_ready(id_ready[1]), .hazard_stall(hazard_stall[1]), .idex_valid(idex_valid[1]),
        .idex_ifid(f1), .ExtOp(c1[5]), .ImmCh(c1[4]), .ShamtCh(c1[3]), .ShiftCtr(c1[2]),
        .MemRead(c1[1]), .MemWrite(c1[0]));

    function automatic stim_t S(logic [31:0] i, bit v = 1, bit st = 0, bit fl = 0, bit r = 0);
        stim_t t;
        t.ins = i; t.v = v; t.st = st; t.fl = fl; t.r = r;
        return t;
    endfunction

    // {ExtOp, ImmCh, ShamtCh, ShiftCtr, MemRead, MemWrite} straight from the opcode tables
    function automatic logic [5:0] ref_dec(logic [31:0] i);
        logic [5:0] op, fn;
        op = i[31:26]; fn = i[5:0];
        return {op inside {6'h08, 6'h09, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h0a, 6'h0b, 6'h01, 6'h07, 6'h06, 6'h20, 6'h24, 6'h28},
                (op >= 6'h08 && op <= 6'h0f) || (op inside {6'h23, 6'h2b, 6'h20, 6'h24, 6'h28}),
                op == 6'h00 && (fn inside {6'h00, 6'h02, 6'h03}),
                op == 6'h00 && (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}),
                op inside {6'h23, 6'h20, 6'h24},
                op inside {6'h2b, 6'h28}};
    endfunction

    function automatic bit m_haz(int k);
        logic [31:0] i;
        logic [5:0] op;
        bit sh, urs, urt;
        i = ifid_reg[31:0]; op = i[31:26];
        sh  = op == 6'h00 && (i[5:0] inside {6'h00, 6'h02, 6'h03});
        urs = !(sh || (op inside {6'h02, 6'h03, 6'h0f}));
        urt = op == 6'h00 || (op inside {6'h04, 6'h05, 6'h2b, 6'h28});
        return ifid_valid && !flush && m_cnt[k] > 0 &&
               ((urs && i[25:21] == m_rt[k]) || (urt && i[20:16] == m_rt[k]));
    endfunction

    function automatic logic [1:0] m_comb(int k);
        return {m_haz(k) && !ex_stall, !ex_stall && !m_haz(k)};
    endfunction

    function automatic logic [W+6:0] obs(int k);
        return k == 0 ? {idex_valid[0], c0, f0} : {idex_valid[1], c1, f1};
    endfunction

    function automatic logic [W+6:0] m_out(int k);
        return {m_v[k], m_c[k], m_ifid[k]};
    endfunction

    task automatic drive(input stim_t t);
        ifid_reg = {$urandom(), t.ins};
        ifid_valid = t.v; ex_stall = t.st; flush = t.fl; rst = t.r;
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            bit h, iss;
            h = m_haz(k);
            if (rst) begin
                m_v[k] = 0; m_c[k] = '0; m_ifid[k] = '0; m_rt[k] = '0; m_cnt[k] = 0;
            end else if (!ex_stall) begin
                iss = ifid_valid && !flush && !h;
                m_v[k] = iss;
                m_c[k] = iss ? ref_dec(ifid_reg[31:0]) : 6'd0;
                m_ifid[k] = ifid_reg;
                if (iss && m_c[k][1] && ifid_reg[20:16] != 5'd0) begin
                    m_rt[k] = ifid_reg[20:16];
                    m_cnt[k] = bub[k];
                end else if (m_cnt[k] > 0) m_cnt[k]--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(S(32'h8C080000, 1, 1, 0, 1));
        tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs(k) !== '0) $display("FAIL reset_regs dut%0d: got %h expected 0", k, obs(k));
            else passed++;
        end
        drive(S(32'h01084820, 1, 1));
        #1;
        total++;
        if ({id_ready, hazard_stall} !== 4'b0000) $display("FAIL reset_stalled got %b expected 0000", {id_ready, hazard_stall});
        else passed++;
        ex_stall = 1'b0;
        #1;
        total++;
        if ({id_ready, hazard_stall} !== 4'b1100) $display("FAIL reset_ready got %b expected 1100", {id_ready, hazard_stall});
        else passed++;
        tick();
    endtask

    task automatic test_decode();
        stim_t q[$];
        drive(S(32'h01084820)); tick();
        total++;
        if ({idex_valid[0], c0} !== 7'b1000000) $display("FAIL decode_add got %b expected 1000000", {idex_valid[0], c0});
        else passed++;
        drive(S(32'h00081100)); tick();
        total++;
        if ({idex_valid[1], c1} !== 7'b1001100) $display("FAIL decode_sll got %b expected 1001100", {idex_valid[1], c1});
        else passed++;
        q = '{S(32'h35080001), S(32'hAC080000), S(32'h11090003), S(32'h81280000), S(32'h08000000),
              S(32'h05010000), S(32'h0109502A), S(32'h00081102), S(32'h00081103), S(32'h01094804),
              S(32'h29280005), S(32'hA1280000), S(32'h1D000002), S(32'h0C000010), S(32'h01094806, 0)};
        foreach (q[s]) begin
            drive(q[s]);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if ({hazard_stall[k], id_ready[k]} !== m_comb(k))
                    $display("FAIL decode_comb step %0d dut%0d: got %b expected %b", s, k, {hazard_stall[k], id_ready[k]}, m_comb(k));
                else passed++;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== m_out(k)) $display("FAIL decode_regs step %0d dut%0d: got %h expected %h", s, k, obs(k), m_out(k));
                else passed++;
            end
        end
    endtask

    task automatic test_load_use();
        stim_t q[$];
        drive(S(0, 0, 0, 0, 1)); tick();
        drive(S(32'h8C080000)); tick();
        total++;
        if ({idex_valid[0], c0} !== 7'b1110010) $display("FAIL lw_ctrl got %b expected 1110010", {idex_valid[0], c0});
        else passed++;
        drive(S(32'h01084820));
        #1;
        total++;
        if ({hazard_stall[0], id_ready[0]} !== 2'b10) $display("FAIL lw_add_stall got %b expected 10", {hazard_stall[0], id_ready[0]});
        else passed++;
        tick();
        total++;
        if (idex_valid[0] !== 1'b0) $display("FAIL lw_add_bubble got %b expected 0", idex_valid[0]);
        else passed++;
        tick();
        total++;
        if ({idex_valid[0], c0} !== 7'b1000000) $display("FAIL lw_add_issue got %b expected 1000000", {idex_valid[0], c0});
        else passed++;
        q = '{S(32'h01084820), S(32'h01084820),
              S(32'h8C080000), S(32'h00081100), S(32'h00081100), S(32'h00081100), S(32'h00081100),
              S(32'h8C080000), S(32'h00004820), S(32'h00081100), S(32'h00081100), S(32'h00081100),
              S(32'h8C000000), S(32'h00004820), S(32'h00004820),
              S(32'h8C080000), S(32'h3C080001), S(32'h00000000),
              S(32'h8C080000), S(32'h8C090000), S(32'h01294820), S(32'h01294820), S(32'h01294820),
              S(32'h01294820), S(32'h01084820)};
        foreach (q[s]) begin
            drive(q[s]);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if ({hazard_stall[k], id_ready[k]} !== m_comb(k))
                    $display("FAIL load_use_comb step %0d dut%0d: got %b expected %b", s, k, {hazard_stall[k], id_ready[k]}, m_comb(k));
                else passed++;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== m_out(k)) $display("FAIL load_use_regs step %0d dut%0d: got %h expected %h", s, k, obs(k), m_out(k));
                else passed++;
            end
        end
    endtask

    task automatic test_stall_flush();
        stim_t q[$];
        q = '{S(32'h8C080000), S(32'h01084820), S(32'h01084820, 1, 1), S(32'h01084820, 1, 1),
              S(32'h01084820, 1, 1), S(32'h01084820), S(32'h01084820), S(32'h01084820),
              S(32'h8C080000), S(32'h01084820, 1, 0, 1), S(32'h01084820), S(32'h01084820, 1, 1, 1),
              S(32'h01084820), S(32'h01084820),
              S(32'h8C080000), S(32'h01084820, 1, 0, 0, 1), S(32'h01084820), S(32'h01084820)};
        foreach (q[s]) begin
            drive(q[s]);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if ({hazard_stall[k], id_ready[k]} !== m_comb(k))
                    $display("FAIL stall_flush_comb step %0d dut%0d: got %b expected %b", s, k, {hazard_stall[k], id_ready[k]}, m_comb(k));
                else passed++;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== m_out(k)) $display("FAIL stall_flush_regs step %0d dut%0d: got %h expected %h", s, k, obs(k), m_out(k));
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] pool[16] = '{32'h8C000000, 32'h80000000, 32'h90000000, 32'hAC000000, 32'hA0000000,
                                  32'h00004820, 32'h00001100, 32'h00001104, 32'h10000003, 32'h14000002,
                                  32'h3C000001, 32'h20000004, 32'h08000000, 32'h0C000000, 32'h04000001,
                                  32'h28000007};
        logic [4:0] regs[3] = '{5'd0, 5'd8, 5'd9};
        stim_t t;
        t = S(32'h0);
        for (int s = 0; s < 400; s++) begin
            if (!(id_ready[0] === 1'b0 && $urandom_range(0, 9) < 7)) begin
                t.ins = pool[$urandom_range(0, 15)];
                t.ins[25:21] = regs[$urandom_range(0, 2)];
                t.ins[20:16] = regs[$urandom_range(0, 2)];
            end
            t.v = $urandom_range(0, 9) != 0;
            t.st = $urandom_range(0, 4) == 0;
            t.fl = $urandom_range(0, 9) == 0;
            t.r = $urandom_range(0, 49) == 0;
            drive(t);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if ({hazard_stall[k], id_ready[k]} !== m_comb(k))
                    $display("FAIL random_comb step %0d dut%0d: got %b expected %b", s, k, {hazard_stall[k], id_ready[k]}, m_comb(k));
                else passed++;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== m_out(k)) $display("FAIL random_regs step %0d dut%0d: got %h expected %h", s, k, obs(k), m_out(k));
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_load_use();
        test_stall_flush();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered ID stage for the pipelined MIPS core. It takes the IF/ID word and decodes the same control set the ID stage has always produced (ExtOp, ImmCh, ShamtCh, ShiftCtr), plus MemRead and MemWrite. The results are latched into an ID/EX control bundle that supports stall, flush and valid handling. It also detects load-use hazards with a configurable bubble count and back-pressures IF/ID while a hazard is pending.

## Interface
- IFID_W, 64: width of IF/ID word; must be ≥ INSTR_LSB+32
- INSTR_LSB, 0: bit position of instruction word inside ifid_reg
- LOAD_BUBBLES, 1: bubbles inserted after a load for a dependent consumer (1..3)
- ENABLE_HAZARD, 1: 0 disables load-use detection (id_ready = !ex_stall)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- ifid_reg  in  IFID_W  IF/ID pipeline word
- ifid_valid  in  1  ifid_reg holds a real instruction
- ex_stall  in  1  downstream holds ID/EX
- flush  in  1  kill the instruction currently in ID
- id_ready  out  1  IF/ID may advance this cycle (combinational)
- hazard_stall  out  1  load-use bubble is being inserted this cycle (combinational)
- idex_valid  out  1  ID/EX holds a real instruction
- idex_ifid  out  IFID_W  registered copy of ifid_reg
- ExtOp, ImmCh, ShamtCh, ShiftCtr, MemRead, MemWrite  out  1 each  registered controls

## Operation
- Field extraction: instr = ifid_reg[INSTR_LSB+:32], op = instr[31:26], funct = instr[5:0], rs = instr[25:21], rt = instr[20:16].
- ExtOp: op ∈ {001000, 001001, 000100, 000101, 100011, 101011, 001010, 001011, 000001, 000111, 000110, 100000, 100100, 101000}.
- ImmCh: op ∈ {001000..001111, 100011, 101011, 100000, 100100, 101000}.
- ShamtCh: op = 0 and funct ∈ {000000, 000010, 000011}.
- ShiftCtr: op = 0 and funct ∈ {000000, 000010, 000011, 000100, 000110, 000111}.
- MemRead: op ∈ {100011, 100000, 100100}.
- MemWrite: op ∈ {101011, 101000}.
- Source usage:
  - uses_rs = !(ShamtCh or op ∈ {000010, 000011, 001111}).
  - uses_rt = op = 0, or op ∈ {000100, 000101, 101011, 101000}.
- Hazard state: pend_rt (5 bits) and pend_cnt (2 bits).
  - When a valid MemRead instruction with rt ≠ 0 issues into ID/EX: pend_rt ← rt, pend_cnt ← LOAD_BUBBLES.
  - Every other advancing edge (ex_stall = 0) with pend_cnt > 0: pend_cnt decrements. This covers bubbles, flushed slots and independent instructions alike.
- hazard = ENABLE_HAZARD & ifid_valid & !flush & pend_cnt > 0 & ((uses_rs & rs = pend_rt) | (uses_rt & rt = pend_rt)).
- hazard_stall = hazard & !ex_stall.
- id_ready = !ex_stall & !hazard.
- Register update, in priority order:
  1. rst: all outputs 0, pend_cnt 0, pend_rt 0.
  2. ex_stall: ID/EX and pend state hold. flush has no effect on ID/EX.
  3. flush or !ifid_valid or hazard: idex_valid ← 0 and all controls ← 0 (bubble). idex_ifid ← ifid_reg.
  4. Otherwise: idex_valid ← 1, controls ← decoded values, idex_ifid ← ifid_reg.
- Controls are forced to 0 whenever idex_valid = 0.

## Timing
- Latency is 1 cycle from ifid_reg to the ID/EX outputs.
- id_ready and hazard_stall are combinational from ifid_reg, ifid_valid, flush, ex_stall and pend state, in the same cycle.
- Dependent instruction directly after a load: held for exactly LOAD_BUBBLES cycles (with no ex_stall), then issues.
- An independent instruction between load and consumer reduces the bubbles by one per intervening instruction.
- A load whose rt = 0 never causes a stall.
- A new load issuing while pend_cnt > 0 overwrites pend_rt and pend_cnt.
- Reset asserted mid-bubble clears everything on that edge. The first cycle after reset has id_ready = !ex_stall.

## Test plan
- Reset, then stream 0x01084820 (add $9,$8,$8) with ifid_valid = 1 → next cycle idex_valid = 1 and all six controls 0. Repeat with 0x00081100 (sll) → ShamtCh = 1, ShiftCtr = 1.
- Stream 0x8C080000 (lw $8), then 0x01084820 with LOAD_BUBBLES = 1 → MemRead = 1, ExtOp = 1, ImmCh = 1 on cycle 1. Cycle 2: hazard_stall = 1, id_ready = 0, idex_valid = 0. add issues on cycle 3.
- LOAD_BUBBLES = 2: lw $8, then sll $2,$8,4 (0x00081100) → two bubbles (rt use detected). With lw $8, add $9,$0,$0 (0x00004820), sll → one bubble only.
- lw $0 (0x8C000000), then 0x00004820 → no bubble. lui $8 (0x3C080001) after lw $8 → no bubble, ImmCh = 1, ExtOp = 0.
- Assert ex_stall for 3 cycles during a pending hazard → ID/EX outputs and pend_cnt held, id_ready = 0, hazard_stall = 0. Release → bubble sequence resumes unchanged.
- flush with a valid dependent instruction in ID → idex_valid = 0 next cycle, hazard_stall = 0 that cycle. Assert rst mid-bubble → all outputs 0 on the next edge.
